fpu_bus_slave: RTL

// - Peripheral-side responder for the FPU 8-bit CPU bus. This block is what the CPU/bench talks to.
// - Holds operand A/B, opcode and result registers, and decodes cs/rd/wr (all active-low).
// - Sequences the arithmetic core through a start/done handshake.
// - Drives the cmd_end IRQ and the busy flag, and holds cmd_end until the CPU asserts end_ack.

---
 rtl/fpu_bus_if.sv | 23 ++
 rtl/fpu_bus_slave.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fpu_bus_if.sv
// CPU-side 8-bit bus of the FPU peripheral: address/data, active-low strobes,
// and the cmd_end/busy status lines returned to the CPU.
interface fpu_bus_if;
  logic [7:0] databus_in;
  logic [7:0] databus_out;
  logic [3:0] addr;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       end_ack;
  logic       cmd_end;
  logic       busy;

  modport master (
    output databus_in, addr, cs, rd, wr, end_ack,
    input  databus_out, cmd_end, busy
  );

  modport slave (
    input  databus_in, addr, cs, rd, wr, end_ack,
    output databus_out, cmd_end, busy
  );
endinterface

// File: rtl/fpu_bus_slave.sv
// FPU bus responder: operand/opcode/result registers, strobe decode and the
// IDLE/RUN/DONE sequencer. Optional core watchdog enabled by FPU_BUS_TIMEOUT_EN.
module fpu_bus_slave #(
  parameter int unsigned OP_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            arst,
  fpu_bus_if.slave        bus,
  output logic [31:0]     core_a,
  output logic [31:0]     core_b,
  output logic [OP_W-1:0] core_op,
  output logic            core_start,
  input  logic            core_done,
  input  logic [31:0]     core_result
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            wr_prev_q;
  logic            start_err_q, start_err_d;
  logic            core_start_q, core_start_d;
  logic            commit, start_cmd;
  logic            timeout_hit, tmo;

  // One commit per wr low pulse: only the falling edge of wr (as sampled) counts.
  assign commit    = !bus.cs && !bus.wr && wr_prev_q;
  assign start_cmd = commit && (bus.addr == 4'd9);

`ifdef FPU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;

  assign timeout_hit = (state_q == S_RUN) && !core_done &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign tmo         = tmo_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_RUN) ? cnt_q + CNT_W'(1) : '0;
      if (state_q == S_IDLE && start_cmd) tmo_q <= 1'b0;
      else if (timeout_hit)               tmo_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign tmo         = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
      wr_prev_q    <= 1'b1;
      start_err_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
      wr_prev_q    <= bus.wr;
      start_err_q  <= start_err_d;
      core_start_q <= core_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    start_err_d  = start_err_q;
    core_start_d = 1'b0;

    if (commit && state_q != S_RUN) begin
      case (bus.addr)
        4'd0, 4'd1, 4'd2, 4'd3: a_d[{bus.addr[1:0], 3'b000} +: 8] = bus.databus_in;
        4'd4, 4'd5, 4'd6, 4'd7: b_d[{bus.addr[1:0], 3'b000} +: 8] = bus.databus_in;
        4'd8:                   op_d = OP_W'(bus.databus_in);
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_cmd) begin
          state_d      = S_RUN;
          core_start_d = 1'b1;
          start_err_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (start_cmd) start_err_d = 1'b1;
        if (core_done) begin
          res_d   = core_result;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          res_d   = 32'h7FC0_0000;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_cmd)   start_err_d = 1'b1;
        if (bus.end_ack) state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.databus_out = '0;
    if (!bus.cs && !bus.rd) begin
      case (bus.addr)
        4'd0, 4'd1, 4'd2, 4'd3: bus.databus_out = a_q[{bus.addr[1:0], 3'b000} +: 8];
        4'd4, 4'd5, 4'd6, 4'd7: bus.databus_out = b_q[{bus.addr[1:0], 3'b000} +: 8];
        4'd8:  bus.databus_out = 8'(op_q);
        4'd9:  bus.databus_out = res_q[7:0];
        4'd10: bus.databus_out = res_q[15:8];
        4'd11: bus.databus_out = res_q[23:16];
        4'd12: bus.databus_out = res_q[31:24];
        4'd13: bus.databus_out = {4'b0000, tmo, start_err_q, bus.cmd_end, bus.busy};
        default: bus.databus_out = '0;
      endcase
    end
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.cmd_end = (state_q == S_DONE);
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign core_op     = op_q;
  assign core_start  = core_start_q;
endmodule
